// File: rtl/output_preprocessor.sv
// Per-channel scale / shift / offset / clamp of packed router samples, serialised
// onto a single DAC stream by a LOAD-MUL-ADD-OUT pipeline with a ready/valid output.
module output_preprocessor #(
  parameter int unsigned W_CHAN    = 16,
  parameter int unsigned W_SEL     = 4,
  parameter int unsigned N_CHAN    = 8,
  parameter int unsigned W_MULT    = 16,
  parameter bit          ACTV_INIT = 1'b1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [W_CHAN*N_CHAN-1:0] data_packed_in,
  input  logic                     param_wr_in,
  input  logic [W_SEL-1:0]         param_chan_in,
  input  logic [2:0]               param_addr_in,
  input  logic [W_MULT-1:0]        param_data_in,
  input  logic                     data_ready_in,
  output logic [W_CHAN-1:0]        data_out,
  output logic [W_SEL-1:0]         chan_out,
  output logic                     data_valid_out
);
  localparam int unsigned W_PROD = W_CHAN + W_MULT;
  localparam int unsigned W_SUM  = W_PROD + 1;
  localparam logic [W_CHAN-1:0] MIN_RST = {1'b1, {(W_CHAN-1){1'b0}}};
  localparam logic [W_CHAN-1:0] MAX_RST = {1'b0, {(W_CHAN-1){1'b1}}};

  typedef enum logic [1:0] {LOAD, MUL, ADD, OUT} state_t;

  logic signed [W_MULT-1:0] mult_q   [N_CHAN];
  logic        [4:0]        rshift_q [N_CHAN];
  logic signed [W_CHAN-1:0] offset_q [N_CHAN];
  logic signed [W_CHAN-1:0] min_q    [N_CHAN];
  logic signed [W_CHAN-1:0] max_q    [N_CHAN];
  logic        [N_CHAN-1:0] en_q;

  state_t                   state_q, state_d;
  logic        [W_SEL-1:0]  idx_q, idx_d, idx_inc;
  logic signed [W_CHAN-1:0] samp_q, samp_d;
  logic signed [W_MULT-1:0] smult_q, smult_d;
  logic        [4:0]        sshift_q, sshift_d;
  logic signed [W_CHAN-1:0] soff_q, soff_d, smin_q, smin_d, smax_q, smax_d;
  logic signed [W_PROD-1:0] prod_q, prod_d, prod_c;
  logic signed [W_SUM-1:0]  sum_c;
  logic        [W_CHAN-1:0] data_q, data_d;
  logic        [W_SEL-1:0]  chan_q, chan_d;
  logic                     valid_q, valid_d;

  logic signed [W_CHAN-1:0] cur_samp, cur_off, cur_min, cur_max;
  logic signed [W_MULT-1:0] cur_mult;
  logic        [4:0]        cur_shift;
  logic                     cur_en;

  // Parameter bank: out-of-range channels never match, unknown addresses fall to default
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < int'(N_CHAN); k++) begin
        mult_q[k]   <= W_MULT'(1);
        rshift_q[k] <= '0;
        offset_q[k] <= '0;
        min_q[k]    <= MIN_RST;
        max_q[k]    <= MAX_RST;
      end
      en_q <= {N_CHAN{ACTV_INIT}};
    end else if (param_wr_in) begin
      for (int k = 0; k < int'(N_CHAN); k++) begin
        if (param_chan_in == W_SEL'(k)) begin
          case (param_addr_in)
            3'd0:    mult_q[k]   <= param_data_in;
            3'd1:    rshift_q[k] <= param_data_in[4:0];
            3'd2:    offset_q[k] <= param_data_in[W_CHAN-1:0];
            3'd3:    min_q[k]    <= param_data_in[W_CHAN-1:0];
            3'd4:    max_q[k]    <= param_data_in[W_CHAN-1:0];
            3'd5:    en_q[k]     <= param_data_in[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Select the sample and parameter set of the channel under idx
  always_comb begin
    cur_samp  = '0;
    cur_mult  = '0;
    cur_shift = '0;
    cur_off   = '0;
    cur_min   = '0;
    cur_max   = '0;
    cur_en    = 1'b0;
    for (int k = 0; k < int'(N_CHAN); k++) begin
      if (idx_q == W_SEL'(k)) begin
        cur_samp  = data_packed_in[k*W_CHAN +: W_CHAN];
        cur_mult  = mult_q[k];
        cur_shift = rshift_q[k];
        cur_off   = offset_q[k];
        cur_min   = min_q[k];
        cur_max   = max_q[k];
        cur_en    = en_q[k];
      end
    end
  end

  assign idx_inc = (idx_q == W_SEL'(N_CHAN - 1)) ? '0 : idx_q + W_SEL'(1);
  assign prod_c  = W_PROD'(samp_q) * W_PROD'(smult_q);
  assign sum_c   = (W_SUM'(prod_q) >>> sshift_q) + W_SUM'(soff_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    samp_d   = samp_q;
    smult_d  = smult_q;
    sshift_d = sshift_q;
    soff_d   = soff_q;
    smin_d   = smin_q;
    smax_d   = smax_q;
    prod_d   = prod_q;
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = valid_q;
    case (state_q)
      LOAD: begin
        if (cur_en) begin
          samp_d   = cur_samp;
          smult_d  = cur_mult;
          sshift_d = cur_shift;
          soff_d   = cur_off;
          smin_d   = cur_min;
          smax_d   = cur_max;
          state_d  = MUL;
        end else begin
          idx_d = idx_inc;
        end
      end
      MUL: begin
        prod_d  = prod_c;
        state_d = ADD;
      end
      ADD: begin
        // An inverted window (min > max) resolves to min
        if ((smin_q > smax_q) || (sum_c < W_SUM'(smin_q))) begin
          data_d = smin_q;
        end else if (sum_c > W_SUM'(smax_q)) begin
          data_d = smax_q;
        end else begin
          data_d = sum_c[W_CHAN-1:0];
        end
        chan_d  = idx_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (valid_q && data_ready_in) begin
          valid_d = 1'b0;
          idx_d   = idx_inc;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      samp_q   <= '0;
      smult_q  <= '0;
      sshift_q <= '0;
      soff_q   <= '0;
      smin_q   <= '0;
      smax_q   <= '0;
      prod_q   <= '0;
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      samp_q   <= samp_d;
      smult_q  <= smult_d;
      sshift_q <= sshift_d;
      soff_q   <= soff_d;
      smin_q   <= smin_d;
      smax_q   <= smax_d;
      prod_q   <= prod_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out       = data_q;
  assign chan_out       = chan_q;
  assign data_valid_out = valid_q;

endmodule

// File: doc/output_preprocessor.md
OUTPUT_PREPROCESSOR -- requirements
Module: output_preprocessor

Interface
REQ-001 SHALL have parameter W_CHAN, 16, width of each signed data channel.
REQ-002 SHALL have parameter W_SEL, 4, width of channel index and channel select signals.
REQ-003 SHALL have parameter N_CHAN, 8, number of packed input channels; N_CHAN <= 2^W_SEL.
REQ-004 SHALL have parameter W_MULT, 16, width of the signed per-channel multiplier.
REQ-005 SHALL have parameter ACTV_INIT, 1, reset value of every channel enable bit.
REQ-006 SHALL have port clk_in  input  1  system clock; the block has one clock, all state changes on its rising edge.
REQ-007 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port data_packed_in  input  W_CHAN*N_CHAN  signed router output channels; channel k occupies bits [k*W_CHAN +: W_CHAN].
REQ-009 SHALL have port param_wr_in  input  1  single-cycle write strobe for a frontpanel parameter.
REQ-010 SHALL have port param_chan_in  input  W_SEL  target channel of the write.
REQ-011 SHALL have port param_addr_in  input  3  target parameter of the write.
REQ-012 SHALL have port param_data_in  input  W_MULT  write data; the low W_CHAN bits are used for W_CHAN-wide parameters.
REQ-013 SHALL have port data_ready_in  input  1  downstream (DAC controller) accepts the sample.
REQ-014 SHALL have port data_out  output  W_CHAN  processed signed sample.
REQ-015 SHALL have port chan_out  output  W_SEL  channel index of data_out.
REQ-016 SHALL have port data_valid_out  output  1  data_out and chan_out are valid.

Function
REQ-017 SHALL hold per-channel registers, addressed by param_addr_in: 0 mult (signed W_MULT), 1 rshift (5 bits), 2 offset (signed W_CHAN), 3 min (signed W_CHAN), 4 max (signed W_CHAN), 5 enable (1 bit).
REQ-018 SHALL write param_data_in into the addressed register on the clock edge where param_wr_in=1; the written value is readable by the next LOAD.
REQ-019 SHALL ignore writes with param_chan_in >= N_CHAN or param_addr_in > 5.
REQ-020 SHALL run an FSM with states LOAD, MUL, ADD, OUT and a channel index idx.
REQ-021 In LOAD, for idx enabled: SHALL snapshot channel idx of data_packed_in and all of channel idx's parameters, then go to MUL.
REQ-022 In LOAD, for idx disabled: SHALL go to LOAD with idx+1 and produce no output; if all channels are disabled, the FSM SHALL cycle through LOAD only.
REQ-023 In MUL: SHALL register the full-precision signed product, W_CHAN+W_MULT bits, then go to ADD.
REQ-024 In ADD: SHALL compute (product >>> rshift) + sign-extended offset as an arithmetic shift in W_CHAN+W_MULT+1 bits, register the sum, then go to OUT.
REQ-025 On entry to OUT: SHALL register data_out = max if sum > max, else min if sum < min, else sum[W_CHAN-1:0]; chan_out = idx; data_valid_out = 1.
REQ-026 Clamp ordering: when min > max the result SHALL equal min.
REQ-027 In OUT: data_out and chan_out SHALL be stable while data_valid_out=1 and data_ready_in=0.
REQ-028 On the edge with data_valid_out=1 and data_ready_in=1: SHALL clear data_valid_out and go to LOAD with idx+1.
REQ-029 idx SHALL wrap from N_CHAN-1 to 0.
REQ-030 Latency: data_valid_out SHALL rise 3 edges after the LOAD edge; with data_ready_in held high, throughput SHALL be one sample per 4 cycles per enabled channel.
REQ-031 A parameter write during MUL, ADD or OUT SHALL NOT affect the sample in flight, only the next LOAD of that channel.
REQ-032 Changes to data_packed_in after the LOAD edge SHALL NOT affect the sample in flight.

Reset
REQ-033 While rst_in=1: data_valid_out SHALL be 0 immediately, regardless of clock.
REQ-034 Reset values: data_out=0, chan_out=0, state=LOAD, idx=0; per channel mult=1, rshift=0, offset=0, min=-2^(W_CHAN-1), max=2^(W_CHAN-1)-1, enable=ACTV_INIT.
REQ-035 Reset asserted mid-handshake SHALL abort the sample; after release, the first output SHALL be channel 0.

Verification
REQ-036 Defaults, ready=1, channel k input = 100*k -> outputs chan 0..7 with data = input, each 4 cycles apart, idx wrapping to 0.
REQ-037 Channel 2 set to mult=3, rshift=1, offset=-10, input 1000 -> data_out=1490 on chan_out=2.
REQ-038 Channel 0 set to mult=200, input 1000 -> data_out=32767; mult=-200 -> -32768; min=50, max=40 -> 50.
REQ-039 Hold ready=0 for 10 cycles during OUT while toggling the input and writing mult -> data_out and chan_out constant; new mult seen on the next pass only.
REQ-040 Disable channels 1 and 3-7 -> only chan 0 and 2 appear; disable all -> data_valid_out stays 0 for 100 cycles.
REQ-041 Assert rst_in asynchronously while valid=1, ready=0 -> valid falls with no clock edge; after release, first chan_out=0 and parameters are back at reset values.
